// File: rtl/secure_array_arbiter.sv
// secure_array_arbiter: fixed-slot L/H access controller for a labeled register array.
// Define SCRUB_ON_DECLASSIFY_EN to allow H->L relabels (entry scrubbed first); otherwise they are rejected.
module secure_array_arbiter #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  parameter int IDX_W  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              l_req_valid,
  input  logic              l_req_we,
  input  logic [IDX_W-1:0]  l_req_idx,
  input  logic [DATA_W-1:0] l_req_wdata,
  output logic              l_req_ready,
  output logic              l_resp_valid,
  output logic              l_resp_err,
  output logic [DATA_W-1:0] l_resp_rdata,
  input  logic              h_req_valid,
  input  logic              h_req_we,
  input  logic [IDX_W-1:0]  h_req_idx,
  input  logic [DATA_W-1:0] h_req_wdata,
  output logic              h_req_ready,
  output logic              h_resp_valid,
  output logic              h_resp_err,
  output logic [DATA_W-1:0] h_resp_rdata,
  input  logic              cfg_valid,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic              cfg_label,
  output logic              cfg_ready,
  output logic              cfg_err,
  output logic [DEPTH-1:0]  entry_label
);

  logic              slot;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  label_q;
  logic              scrub_now;
  logic [IDX_W-1:0]  scrub_idx;
  logic              cfg_err_d;

  function automatic logic in_range(input logic [IDX_W-1:0] idx);
    return int'(idx) < DEPTH;
  endfunction

  // The slot bit depends on nothing but reset, so H activity cannot shift L timing.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) slot <= 1'b0;
    else       slot <= ~slot;
  end

  assign l_req_ready = ~slot;
  assign h_req_ready = slot & ~scrub_now;
  assign entry_label = label_q;

  logic              l_acc, l_ok, l_lbl, l_err, l_wr;
  logic              h_acc, h_ok, h_lbl, h_err, h_wr;
  logic [DATA_W-1:0] l_rd, h_rd;

  assign l_acc = l_req_valid & l_req_ready;
  assign l_ok  = in_range(l_req_idx);
  assign l_lbl = l_ok ? label_q[l_req_idx] : 1'b1;
  assign l_err = ~l_ok | (~l_req_we & l_lbl);
  assign l_wr  = l_acc & l_req_we & ~l_err;
  assign l_rd  = l_ok ? mem[l_req_idx] : '0;

  assign h_acc = h_req_valid & h_req_ready;
  assign h_ok  = in_range(h_req_idx);
  assign h_lbl = h_ok ? label_q[h_req_idx] : 1'b1;
  assign h_err = ~h_ok | (h_req_we & ~h_lbl);
  assign h_wr  = h_acc & h_req_we & ~h_err;
  assign h_rd  = h_ok ? mem[h_req_idx] : '0;

  logic cfg_acc, cfg_ok, cfg_old, cfg_declass, cfg_apply;
  assign cfg_acc     = cfg_valid & cfg_ready;
  assign cfg_ok      = in_range(cfg_idx);
  assign cfg_old     = cfg_ok ? label_q[cfg_idx] : 1'b0;
  assign cfg_declass = cfg_acc & cfg_ok & cfg_old & ~cfg_label;
  assign cfg_apply   = cfg_acc & cfg_ok & ~cfg_declass;

`ifdef SCRUB_ON_DECLASSIFY_EN
  typedef enum logic {IDLE, SCRUB_PEND} state_t;
  state_t state, state_nx;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:       if (cfg_declass) state_nx = SCRUB_PEND;
      SCRUB_PEND: if (slot)        state_nx = IDLE;
      default:                     state_nx = IDLE;
    endcase
  end

  always_comb begin
    cfg_ready = 1'b0;
    scrub_now = 1'b0;
    case (state)
      IDLE:       cfg_ready = 1'b1;
      SCRUB_PEND: scrub_now = slot;
      default:    cfg_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)            scrub_idx <= '0;
    else if (cfg_declass) scrub_idx <= cfg_idx;
  end

  assign cfg_err_d = cfg_acc & ~cfg_ok;
`else
  assign cfg_ready = 1'b1;
  assign scrub_now = 1'b0;
  assign scrub_idx = '0;
  assign cfg_err_d = cfg_acc & (~cfg_ok | cfg_declass);
`endif

  // L writes land in slot 0, H writes and the scrub in slot 1, so they never collide.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the array is reset explicitly so no stale H data survives into a fresh session.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (l_wr)      mem[l_req_idx] <= l_req_wdata;
      if (h_wr)      mem[h_req_idx] <= h_req_wdata;
      if (scrub_now) mem[scrub_idx] <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      label_q <= '1;
    end else begin
      if (cfg_apply) label_q[cfg_idx]   <= cfg_label;
      if (scrub_now) label_q[scrub_idx] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      l_resp_valid <= 1'b0;
      l_resp_err   <= 1'b0;
      l_resp_rdata <= '0;
      h_resp_valid <= 1'b0;
      h_resp_err   <= 1'b0;
      h_resp_rdata <= '0;
      cfg_err      <= 1'b0;
    end else begin
      l_resp_valid <= l_acc;
      l_resp_err   <= l_acc & l_err;
      l_resp_rdata <= (l_acc & ~l_req_we & ~l_err) ? l_rd : '0;
      h_resp_valid <= h_acc;
      h_resp_err   <= h_acc & h_err;
      h_resp_rdata <= (h_acc & ~h_req_we & ~h_err) ? h_rd : '0;
      cfg_err      <= cfg_err_d;
    end
  end

endmodule

// File: tb/tb_secure_array_arbiter.sv
// Scoreboard bench for secure_array_arbiter; expectations come from a cycle model of slots, labels and data.
module tb_secure_array_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        l_req_valid = 1'b0, l_req_we = 1'b0;
  logic [1:0]  l_req_idx = '0;
  logic [15:0] l_req_wdata = '0;
  logic        l_req_ready, l_resp_valid, l_resp_err;
  logic [15:0] l_resp_rdata;
  logic        h_req_valid = 1'b0, h_req_we = 1'b0;
  logic [1:0]  h_req_idx = '0;
  logic [15:0] h_req_wdata = '0;
  logic        h_req_ready, h_resp_valid, h_resp_err;
  logic [15:0] h_resp_rdata;
  logic        cfg_valid = 1'b0;
  logic [1:0]  cfg_idx = '0;
  logic        cfg_label = 1'b0;
  logic        cfg_ready, cfg_err;
  logic [3:0]  entry_label;

  secure_array_arbiter dut (
    .clk(clk), .reset(reset),
    .l_req_valid(l_req_valid), .l_req_we(l_req_we), .l_req_idx(l_req_idx), .l_req_wdata(l_req_wdata),
    .l_req_ready(l_req_ready), .l_resp_valid(l_resp_valid), .l_resp_err(l_resp_err), .l_resp_rdata(l_resp_rdata),
    .h_req_valid(h_req_valid), .h_req_we(h_req_we), .h_req_idx(h_req_idx), .h_req_wdata(h_req_wdata),
    .h_req_ready(h_req_ready), .h_resp_valid(h_resp_valid), .h_resp_err(h_resp_err), .h_resp_rdata(h_resp_rdata),
    .cfg_valid(cfg_valid), .cfg_idx(cfg_idx), .cfg_label(cfg_label),
    .cfg_ready(cfg_ready), .cfg_err(cfg_err), .entry_label(entry_label)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    int          due;
    logic        err;
    logic [15:0] rdata;
  } exp_t;

  exp_t l_q[$];
  exp_t h_q[$];
  exp_t mon_e;

  // Reference model state
  bit          m_slot;
  bit          m_pend;
  logic [1:0]  m_idx;
  logic [3:0]  m_label;
  logic [15:0] m_mem [4];

  // Responses are due exactly one cycle after acceptance.
  always @(negedge clk) begin
    if (!reset) begin
      if (l_q.size() > 0 && l_q[0].due == cyc) begin
        mon_e = l_q.pop_front();
        check("l_resp_valid", l_resp_valid, 1);
        check("l_resp_err", l_resp_err, mon_e.err);
        check("l_resp_rdata", l_resp_rdata, mon_e.rdata);
      end else if (l_resp_valid) begin
        check("l_resp_spurious", l_resp_valid, 0);
      end
      if (h_q.size() > 0 && h_q[0].due == cyc) begin
        mon_e = h_q.pop_front();
        check("h_resp_valid", h_resp_valid, 1);
        check("h_resp_err", h_resp_err, mon_e.err);
        check("h_resp_rdata", h_resp_rdata, mon_e.rdata);
      end else if (h_resp_valid) begin
        check("h_resp_spurious", h_resp_valid, 0);
      end
    end
  end

  task automatic model_reset();
    m_slot = 1'b0;
    m_pend = 1'b0;
    m_idx = '0;
    m_label = 4'hF;
    for (int i = 0; i < 4; i++) m_mem[i] = 16'h0;
  endtask

  task automatic step(input bit lv, input bit lwe, input logic [1:0] li, input logic [15:0] lwd,
                      input bit hv, input bit hwe, input logic [1:0] hi, input logic [15:0] hwd,
                      input bit cv, input logic [1:0] ci, input bit cl);
    bit scrub, ex_lr, ex_hr, ex_cr, l_acc, h_acc, cfg_acc, decl, ex_cerr;
    exp_t e;
    scrub = m_pend && m_slot;
    ex_lr = !m_slot;
    ex_hr = m_slot && !scrub;
    ex_cr = !m_pend;
    check("l_req_ready", l_req_ready, ex_lr);
    check("h_req_ready", h_req_ready, ex_hr);
    check("cfg_ready", cfg_ready, ex_cr);
    l_req_valid = lv; l_req_we = lwe; l_req_idx = li; l_req_wdata = lwd;
    h_req_valid = hv; h_req_we = hwe; h_req_idx = hi; h_req_wdata = hwd;
    cfg_valid = cv; cfg_idx = ci; cfg_label = cl;
    l_acc = lv && ex_lr;
    h_acc = hv && ex_hr;
    cfg_acc = cv && ex_cr;
    decl = cfg_acc && m_label[ci] && !cl;
    if (l_acc) begin
      e.due = cyc + 1;
      e.err = !lwe && m_label[li];
      e.rdata = (lwe || e.err) ? 16'h0 : m_mem[li];
      l_q.push_back(e);
    end
    if (h_acc) begin
      e.due = cyc + 1;
      e.err = hwe && !m_label[hi];
      e.rdata = hwe ? 16'h0 : m_mem[hi];
      h_q.push_back(e);
    end
    @(posedge clk);
    #1;
    if (l_acc && lwe) m_mem[li] = lwd;
    if (h_acc && hwe && m_label[hi]) m_mem[hi] = hwd;
    ex_cerr = 1'b0;
`ifdef SCRUB_ON_DECLASSIFY_EN
    if (scrub) begin
      m_mem[m_idx] = 16'h0;
      m_label[m_idx] = 1'b0;
      m_pend = 1'b0;
    end
    if (decl) begin
      m_pend = 1'b1;
      m_idx = ci;
    end else if (cfg_acc) begin
      m_label[ci] = cl;
    end
`else
    if (decl) ex_cerr = 1'b1;
    else if (cfg_acc) m_label[ci] = cl;
`endif
    m_slot = !m_slot;
    check("cfg_err", cfg_err, ex_cerr);
    check("entry_label", entry_label, m_label);
  endtask

  task automatic idle();
    step(0, 0, 0, 16'h0, 0, 0, 0, 16'h0, 0, 0, 0);
  endtask

  task automatic l_op(input bit we, input logic [1:0] idx, input logic [15:0] wd);
    while (m_slot) idle();
    step(1, we, idx, wd, 0, 0, 0, 16'h0, 0, 0, 0);
  endtask

  task automatic h_op(input bit we, input logic [1:0] idx, input logic [15:0] wd);
    while (!(m_slot && !m_pend)) idle();
    step(0, 0, 0, 16'h0, 1, we, idx, wd, 0, 0, 0);
  endtask

  task automatic cfg_op(input logic [1:0] idx, input bit lab);
    while (m_slot || m_pend) idle();
    step(0, 0, 0, 16'h0, 0, 0, 0, 16'h0, 1, idx, lab);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    l_req_valid = 0; l_req_we = 0; l_req_idx = 0; l_req_wdata = 0;
    h_req_valid = 0; h_req_we = 0; h_req_idx = 0; h_req_wdata = 0;
    cfg_valid = 0; cfg_idx = 0; cfg_label = 0;
    @(posedge clk);
    #1;
    l_q.delete();
    h_q.delete();
    check("rst_l_req_ready", l_req_ready, 1);
    check("rst_cfg_ready", cfg_ready, 1);
    check("rst_entry_label", entry_label, 4'hF);
    check("rst_l_resp", {l_resp_valid, l_resp_err, l_resp_rdata}, 18'h0);
    check("rst_h_resp", {h_resp_valid, h_resp_err, h_resp_rdata}, 18'h0);
    check("rst_cfg_err", cfg_err, 0);
    reset = 1'b0;
    model_reset();
  endtask

  localparam int RUN_N = 40;
  logic [17:0] tr_a [RUN_N];
  logic [17:0] tr_b [RUN_N];

  task automatic l_stream_run(input bit h_busy, output logic [17:0] tr [RUN_N]);
    do_reset();
    cfg_op(0, 0);
    idle();
    idle();
    cfg_op(1, 0);
    idle();
    idle();
    for (int i = 0; i < RUN_N; i++) begin
      step(i % 3 != 2, i % 2 == 0, 2'(i % 4), 16'h100 + 16'(i),
           h_busy && ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           2'($urandom_range(0, 3)), 16'($urandom), 0, 0, 0);
      tr[i] = {l_resp_valid, l_resp_err, l_resp_rdata};
    end
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    do_reset();

    // Fresh entries are H: L read errors, H read sees zero.
    l_op(0, 2, 16'h0);
    check("tp_l_rd_h_err", l_resp_err, 1);
    check("tp_l_rd_h_data", l_resp_rdata, 16'h0);
    h_op(0, 2, 16'h0);
    check("tp_h_rd_valid", h_resp_valid, 1);
    check("tp_h_rd_data", h_resp_rdata, 16'h0);
    check("tp_h_rd_err", h_resp_err, 0);

    // Relabel entry 1 to L, then L write/read in consecutive L slots.
    cfg_op(1, 0);
    idle();
    l_op(1, 1, 16'hBEEF);
    l_op(0, 1, 16'h0);
`ifdef SCRUB_ON_DECLASSIFY_EN
    check("tp_raw_lbl", entry_label[1], 0);
    check("tp_raw_err", l_resp_err, 0);
    check("tp_raw_data", l_resp_rdata, 16'hBEEF);
`else
    check("tp_raw_lbl", entry_label[1], 1);
    check("tp_raw_err", l_resp_err, 1);
    check("tp_raw_data", l_resp_rdata, 16'h0);
`endif

    // H write-down to an L entry is refused.
    cfg_op(0, 0);
    idle();
    h_op(1, 0, 16'h1234);
`ifdef SCRUB_ON_DECLASSIFY_EN
    check("tp_h_wr_l_err", h_resp_err, 1);
`else
    check("tp_h_wr_l_err", h_resp_err, 0);
`endif
    l_op(0, 0, 16'h0);
    check("tp_h_wr_l_data", l_resp_rdata, 16'h0);

    // Declassify a dirty H entry.
    h_op(1, 3, 16'hCAFE);
    cfg_op(3, 0);
`ifdef SCRUB_ON_DECLASSIFY_EN
    check("tp_scrub_cfg_ready", cfg_ready, 0);
    check("tp_scrub_h_ready", h_req_ready, 0);
    check("tp_scrub_lbl_pend", entry_label[3], 1);
    idle();
    check("tp_scrub_lbl_done", entry_label[3], 0);
    check("tp_scrub_cfg_ready2", cfg_ready, 1);
    l_op(0, 3, 16'h0);
    check("tp_scrub_l_err", l_resp_err, 0);
    check("tp_scrub_l_data", l_resp_rdata, 16'h0);
`else
    check("tp_rej_cfg_err", cfg_err, 1);
    check("tp_rej_lbl", entry_label[3], 1);
    idle();
    check("tp_rej_cfg_err_pulse", cfg_err, 0);
    h_op(0, 3, 16'h0);
    check("tp_rej_data", h_resp_rdata, 16'hCAFE);
`endif
    // L->H upgrade is always allowed and immediate.
    cfg_op(1, 1);
    check("tp_upgrade_lbl", entry_label[1], 1);
    idle();

    // L timing and values must not depend on H activity.
    l_stream_run(1'b1, tr_a);
    l_stream_run(1'b0, tr_b);
    for (int i = 0; i < RUN_N; i++) check($sformatf("nonint_%0d", i), tr_a[i], tr_b[i]);

    // Reset in the middle of a pending scrub.
    do_reset();
    h_op(1, 2, 16'h5A5A);
    cfg_op(2, 0);
    do_reset();
    check("midrst_lbl2", entry_label[2], 1);
    h_op(0, 2, 16'h0);
    check("midrst_data", h_resp_rdata, 16'h0);
    idle();
    idle();

    check("l_q_drained", l_q.size(), 0);
    check("h_q_drained", h_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
